// File: rtl/mc_control.sv
// Multicycle control FSM for the 16-bit core: fetch, decode, execute,
// memory and write-back sequencing against a wait-state memory port.
package riscv_pkg;

    typedef enum logic [2:0] {
        R_OP   = 3'd0,
        I_OP   = 3'd1,
        L_OP   = 3'd2,
        S_OP   = 3'd3,
        B_OP   = 3'd4,
        J_OP   = 3'd5,
        JR_OP  = 3'd6,
        BAD_OP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        WB_ALU          = 2'd0,
        WB_MEM          = 2'd1,
        WB_PC_PLUS_FOUR = 2'd2
    } wb_sel_t;

endpackage

module mc_control
    import riscv_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  opcode_t         op_i,
    input  logic [1:0]      func2_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            mem_ready_i,
    output logic            instr_req_o,
    output logic            ir_we_o,
    output logic            mem_req_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic [1:0]      wb_sel_o,
    output logic            write_en_o,
    output logic            imm_en_o,
    output logic            jal_en_o,
    output logic            jalr_en_o,
    output logic            branch_en_o,
    output logic            pc_we_o,
    output logic            fault_o,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t     state_q;
    state_t     state_d;
    opcode_t    op_q;
    logic       cond_q;
    logic       cond_d;
    logic [7:0] wait_q;
    logic       timeout;
    logic       waiting;

    assign timeout = (wait_q == WAIT_LIM);
    assign state_o = state_q;

    // Operands are valid in DECODE (IR already loaded), so the
    // condition is captured there and drives next-PC in EXEC.
    always_comb begin
        cond_d = 1'b0;
        unique case (func2_i)
            2'b00: cond_d = (rs1_data_i == rs2_data_i);
            2'b01: cond_d = (rs1_data_i != rs2_data_i);
            2'b10: cond_d = ($signed(rs1_data_i) < $signed(rs2_data_i));
            2'b11: cond_d = (rs1_data_i < rs2_data_i);
            default: cond_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= R_OP;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q   <= op_i;
                cond_q <= cond_d;
            end
        end
    end

    assign waiting = (state_q == S_FETCH || state_q == S_MEM)
                   && (state_d == state_q);

    // Counter restarts whenever FETCH or MEM is entered afresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= 8'd0;
        end else if (waiting) begin
            wait_q <= wait_q + 8'd1;
        end else begin
            wait_q <= 8'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_req_o = 1'b0;
        ir_we_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        wb_sel_o    = WB_ALU;
        write_en_o  = 1'b0;
        imm_en_o    = 1'b0;
        jal_en_o    = 1'b0;
        jalr_en_o   = 1'b0;
        branch_en_o = 1'b0;
        pc_we_o     = 1'b0;
        fault_o     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                instr_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                state_d = (op_i == BAD_OP) ? S_FAULT : S_EXEC;
            end

            S_EXEC: begin
                imm_en_o = (op_q == I_OP) || (op_q == L_OP)
                         || (op_q == S_OP);
                unique case (1'b1)
                    (op_q == R_OP), (op_q == I_OP),
                    (op_q == J_OP), (op_q == JR_OP): begin
                        state_d = S_WB;
                    end
                    (op_q == L_OP), (op_q == S_OP): begin
                        state_d = S_MEM;
                    end
                    (op_q == B_OP): begin
                        pc_we_o     = 1'b1;
                        branch_en_o = cond_q;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_FAULT;
                endcase
            end

            S_MEM: begin
                mem_req_o   = 1'b1;
                mem_read_o  = (op_q == L_OP);
                mem_write_o = (op_q == S_OP);
                if (mem_ready_i) begin
                    if (op_q == L_OP) begin
                        state_d = S_WB;
                    end else begin
                        pc_we_o = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_WB: begin
                write_en_o = 1'b1;
                pc_we_o    = 1'b1;
                imm_en_o   = (op_q == I_OP);
                unique case (1'b1)
                    (op_q == L_OP):  wb_sel_o = WB_MEM;
                    (op_q == J_OP),
                    (op_q == JR_OP): wb_sel_o = WB_PC_PLUS_FOUR;
                    default:         wb_sel_o = WB_ALU;
                endcase
                jal_en_o  = (op_q == J_OP);
                jalr_en_o = (op_q == JR_OP);
                state_d   = S_FETCH;
            end

            S_FAULT: begin
                fault_o = 1'b1;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control.
// Steps align to 1 ns after each rising edge.
module tb_mc_control;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    opcode_t     op;
    logic [1:0]  f2;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        instr_req;
    logic        ir_we;
    logic        mem_req;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  wb_sel;
    logic        write_en;
    logic        imm_en;
    logic        jal_en;
    logic        jalr_en;
    logic        branch_en;
    logic        pc_we;
    logic        fault;
    logic [2:0]  state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]  bf [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [15:0] ba [4] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'h1234};
    logic [15:0] bb [4] = '{16'h0001, 16'h0001, 16'h1234, 16'h1234};
    logic        be [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    mc_control #(.XLEN(16), .MAX_WAIT(15)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_i        (op),
        .func2_i     (f2),
        .rs1_data_i  (a),
        .rs2_data_i  (b),
        .mem_ready_i (ready),
        .instr_req_o (instr_req),
        .ir_we_o     (ir_we),
        .mem_req_o   (mem_req),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .wb_sel_o    (wb_sel),
        .write_en_o  (write_en),
        .imm_en_o    (imm_en),
        .jal_en_o    (jal_en),
        .jalr_en_o   (jalr_en),
        .branch_en_o (branch_en),
        .pc_we_o     (pc_we),
        .fault_o     (fault),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        op    = R_OP;
        f2    = 2'b00;
        a     = 16'h0;
        b     = 16'h0;
        ready = 1'b1;
        #2;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_instr_req", 16'(instr_req), 16'd0);
        chk("rst_pc_we", 16'(pc_we), 16'd0);
        chk("rst_write_en", 16'(write_en), 16'd0);
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_fault", 16'(fault), 16'd0);
        chk("rst_wb_sel", 16'(wb_sel), 16'(WB_ALU));

        tick;
        rst_n = 1'b1;
        chk("idle_after_release", 16'(state), 16'd0);

        tick;
        chk("r_fetch_state", 16'(state), 16'd1);
        chk("r_instr_req", 16'(instr_req), 16'd1);
        chk("r_ir_we", 16'(ir_we), 16'd1);
        chk("r_fetch_pc_we", 16'(pc_we), 16'd0);
        tick;
        chk("r_decode_state", 16'(state), 16'd2);
        chk("r_decode_pc_we", 16'(pc_we), 16'd0);
        chk("r_decode_we", 16'(write_en), 16'd0);
        tick;
        chk("r_exec_state", 16'(state), 16'd3);
        chk("r_exec_pc_we", 16'(pc_we), 16'd0);
        op = B_OP;
        tick;
        chk("r_wb_state", 16'(state), 16'd5);
        chk("r_wb_we", 16'(write_en), 16'd1);
        chk("r_wb_pc_we", 16'(pc_we), 16'd1);
        chk("r_wb_sel", 16'(wb_sel), 16'(WB_ALU));
        chk("r_wb_jal", 16'(jal_en), 16'd0);

        op = L_OP;
        tick;
        chk("r_next_fetch", 16'(state), 16'd1);
        chk("r_next_we", 16'(write_en), 16'd0);
        chk("r_next_pc_we", 16'(pc_we), 16'd0);
        tick;
        chk("l_decode", 16'(state), 16'd2);
        tick;
        chk("l_exec", 16'(state), 16'd3);
        chk("l_exec_imm", 16'(imm_en), 16'd1);
        ready = 1'b0;
        tick;
        chk("l_mem1", 16'(state), 16'd4);
        chk("l_mem1_req", 16'(mem_req), 16'd1);
        chk("l_mem1_read", 16'(mem_read), 16'd1);
        chk("l_mem1_write", 16'(mem_write), 16'd0);
        tick;
        chk("l_mem2", 16'(state), 16'd4);
        tick;
        chk("l_mem3", 16'(state), 16'd4);
        tick;
        chk("l_mem4", 16'(state), 16'd4);
        chk("l_mem4_read", 16'(mem_read), 16'd1);
        ready = 1'b1;
        #1;
        chk("l_mem4_pc_we", 16'(pc_we), 16'd0);
        tick;
        chk("l_wb", 16'(state), 16'd5);
        chk("l_wb_sel", 16'(wb_sel), 16'(WB_MEM));
        chk("l_wb_we", 16'(write_en), 16'd1);
        chk("l_wb_pc_we", 16'(pc_we), 16'd1);
        chk("l_wb_read", 16'(mem_read), 16'd0);
        tick;
        chk("l_next_fetch", 16'(state), 16'd1);

        for (int i = 0; i < 4; i++) begin
            op = B_OP;
            f2 = bf[i];
            a  = ba[i];
            b  = bb[i];
            tick;
            chk($sformatf("b%0d_decode", i), 16'(state), 16'd2);
            tick;
            chk($sformatf("b%0d_exec", i), 16'(state), 16'd3);
            chk($sformatf("b%0d_branch_en", i), 16'(branch_en),
                16'(be[i]));
            chk($sformatf("b%0d_pc_we", i), 16'(pc_we), 16'd1);
            tick;
            chk($sformatf("b%0d_fetch", i), 16'(state), 16'd1);
            chk($sformatf("b%0d_br_clr", i), 16'(branch_en), 16'd0);
        end

        op = JR_OP;
        tick;
        tick;
        tick;
        chk("jr_wb", 16'(state), 16'd5);
        chk("jr_wb_sel", 16'(wb_sel), 16'(WB_PC_PLUS_FOUR));
        chk("jr_jalr", 16'(jalr_en), 16'd1);
        chk("jr_jal", 16'(jal_en), 16'd0);
        tick;

        op = S_OP;
        tick;
        tick;
        chk("s_exec_imm", 16'(imm_en), 16'd1);
        tick;
        chk("s_mem", 16'(state), 16'd4);
        chk("s_mem_write", 16'(mem_write), 16'd1);
        chk("s_mem_pc_we", 16'(pc_we), 16'd1);
        tick;
        chk("s_next_fetch", 16'(state), 16'd1);

        tick;
        tick;
        ready = 1'b0;
        tick;
        chk("s2_mem", 16'(state), 16'd4);
        chk("s2_mem_write", 16'(mem_write), 16'd1);
        chk("s2_pc_we", 16'(pc_we), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s2_abort_write", 16'(mem_write), 16'd0);
        chk("s2_abort_state", 16'(state), 16'd0);
        chk("s2_abort_pc_we", 16'(pc_we), 16'd0);

        tick;
        rst_n = 1'b1;
        tick;
        chk("to_fetch1", 16'(state), 16'd1);
        repeat (15) tick;
        chk("to_fetch16", 16'(state), 16'd1);
        chk("to_fetch16_fault", 16'(fault), 16'd0);
        tick;
        chk("to_fault_state", 16'(state), 16'd7);
        chk("to_fault", 16'(fault), 16'd1);
        chk("to_fault_instr", 16'(instr_req), 16'd0);
        repeat (3) tick;
        ready = 1'b1;
        tick;
        chk("to_sticky_state", 16'(state), 16'd7);
        chk("to_sticky_fault", 16'(fault), 16'd1);

        rst_n = 1'b0;
        #1;
        chk("to_rst_clear", 16'(fault), 16'd0);
        ready = 1'b0;
        op    = R_OP;
        tick;
        rst_n = 1'b1;
        tick;
        repeat (15) tick;
        ready = 1'b1;
        #1;
        chk("ok16_ir_we", 16'(ir_we), 16'd1);
        tick;
        chk("ok16_decode", 16'(state), 16'd2);
        chk("ok16_fault", 16'(fault), 16'd0);

        op = BAD_OP;
        tick;
        chk("ill_state", 16'(state), 16'd7);
        chk("ill_fault", 16'(fault), 16'd1);
        chk("ill_pc_we", 16'(pc_we), 16'd0);
        tick;
        chk("ill_sticky", 16'(state), 16'd7);
        rst_n = 1'b0;
        #1;
        chk("ill_rst_state", 16'(state), 16'd0);
        chk("ill_rst_fault", 16'(fault), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
